// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer scan-out path.
//   rgb565_t   : packed RGB565 pixel as stored in the frame-buffer BRAM
//   fb_width   : frame-buffer width for a given active width and scale
//   fb_height  : frame-buffer height for a given active height and scale
//   fb_size    : pixels in one frame-buffer bank
//   expand565  : RGB565 -> RGB888 by replicating the top bits into the LSBs
package fb_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic int fb_width(int active_h, int scale_log2);
    return active_h >> scale_log2;
  endfunction

  function automatic int fb_height(int active_v, int scale_log2);
    return active_v >> scale_log2;
  endfunction

  function automatic int fb_size(int width, int height);
    return width * height;
  endfunction

  // Replicating the MSBs maps full-scale 5/6-bit values to 8'hFF and zero to 8'h00.
  function automatic logic [23:0] expand565(rgb565_t p);
    return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-length shift register with asynchronous active-low clear.
//   clk_pixel_in : clock
//   rst_n_in     : async reset, active low; clears every stage
//   d            : WIDTH-bit input, sampled every cycle
//   q            : d delayed by DEPTH cycles
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_pixel_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fb_scan_reader.sv
// Scan-out reader for a double-buffered, integer-downscaled RGB565 frame buffer.
// Turns the pixel-timing stream into BRAM read addresses, expands the returned
// pixel to RGB888 and delays the timing flags so everything leaves aligned.
//   clk_pixel_in, rst_n_in        : pixel clock, async active-low reset
//   hcount_in, vcount_in          : current raster position
//   hs_in, vs_in, ad_in, nf_in    : syncs, active draw, new-frame pulse
//   swap_req_in                   : one-cycle request to flip the displayed bank
//   addr_out, rd_en_out           : BRAM read port (registered)
//   data_in                       : BRAM read data, RGB565, BRAM_LATENCY after addr_out
//   red_out, green_out, blue_out  : RGB888 colour
//   hs_out, vs_out, ad_out, nf_out: timing flags aligned with colour
//   bank_out                      : bank currently being displayed
//   swap_ack_out                  : one-cycle pulse when the bank flips
module fb_scan_reader
  import fb_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int SCALE_LOG2      = 2,
  parameter int BRAM_LATENCY    = 2,
  parameter int H_WIDTH         = 11,
  parameter int V_WIDTH         = 10,
  localparam int FB_WIDTH  = fb_width(ACTIVE_H_PIXELS, SCALE_LOG2),
  localparam int FB_HEIGHT = fb_height(ACTIVE_LINES, SCALE_LOG2),
  localparam int FB_SIZE   = fb_size(FB_WIDTH, FB_HEIGHT),
  localparam int AW        = $clog2(2 * FB_SIZE)
) (
  input  logic               clk_pixel_in,
  input  logic               rst_n_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               ad_in,
  input  logic               nf_in,
  input  logic               swap_req_in,
  output logic [AW-1:0]      addr_out,
  output logic               rd_en_out,
  input  logic [15:0]        data_in,
  output logic [7:0]         red_out,
  output logic [7:0]         green_out,
  output logic [7:0]         blue_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic               ad_out,
  output logic               nf_out,
  output logic               bank_out,
  output logic               swap_ack_out
);

  localparam logic [AW-1:0]      BANK1_BASE = AW'(FB_SIZE);
  localparam logic [AW-1:0]      ROW_STEP   = AW'(FB_WIDTH);
  localparam logic [H_WIDTH-1:0] H_LAST     = H_WIDTH'(ACTIVE_H_PIXELS - 1);
  localparam logic [V_WIDTH-1:0] V_LIMIT    = V_WIDTH'(ACTIVE_LINES);

  logic [AW-1:0] row_base;
  logic          swap_pending;
  logic [AW-1:0] bank_base;
  logic [AW-1:0] col_offset;
  logic          row_done;
  logic [3:0]    flags_aligned;   // {hs, vs, ad, nf} lined up with data_in
  logic [23:0]   rgb888;

  assign bank_base  = bank_out ? BANK1_BASE : '0;
  assign col_offset = AW'(hcount_in >> SCALE_LOG2);
  // The last pixel of the last source line of each scaled row advances the row.
  assign row_done   = (hcount_in == H_LAST) && (vcount_in < V_LIMIT) &&
                      (&vcount_in[SCALE_LOG2-1:0]);
  assign rgb888     = expand565(rgb565_t'(data_in));

  // Address stage; addr_out holds through blanking.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_out  <= '0;
      rd_en_out <= 1'b0;
      row_base  <= '0;
    end else begin
      rd_en_out <= ad_in;
      if (ad_in) addr_out <= bank_base + row_base + col_offset;
      if (nf_in)         row_base <= '0;
      else if (row_done) row_base <= row_base + ROW_STEP;
    end
  end

  // Bank flips only on the new-frame pulse so a frame is never torn.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bank_out     <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack_out <= 1'b0;
    end else begin
      swap_ack_out <= 1'b0;
      if (nf_in) begin
        if (swap_pending || swap_req_in) begin
          bank_out     <= ~bank_out;
          swap_ack_out <= 1'b1;
        end
        swap_pending <= 1'b0;
      end else if (swap_req_in) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Address register + BRAM latency; the output register below adds the last stage.
  sig_delay #(
    .WIDTH(4),
    .DEPTH(BRAM_LATENCY + 1)
  ) u_flag_delay (
    .clk_pixel_in(clk_pixel_in),
    .rst_n_in    (rst_n_in),
    .d           ({hs_in, vs_in, ad_in, nf_in}),
    .q           (flags_aligned)
  );

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      {hs_out, vs_out, ad_out, nf_out}  <= '0;
      {red_out, green_out, blue_out}    <= '0;
    end else begin
      {hs_out, vs_out, ad_out, nf_out}  <= flags_aligned;
      {red_out, green_out, blue_out}    <= flags_aligned[1] ? rgb888 : 24'h0;
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
module tb_fb_scan_reader;

  localparam int AW      = 17;
  localparam int FB_SIZE = 57600;

  logic          clk_pixel_in = 1'b0;
  logic          rst_n_in;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          hs_in, vs_in, ad_in, nf_in, swap_req_in;
  logic [AW-1:0] addr_out;
  logic          rd_en_out;
  logic [15:0]   data_in;
  logic [7:0]    red_out, green_out, blue_out;
  logic          hs_out, vs_out, ad_out, nf_out, bank_out, swap_ack_out;

  fb_scan_reader dut (
    .clk_pixel_in(clk_pixel_in), .rst_n_in(rst_n_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hs_in(hs_in), .vs_in(vs_in), .ad_in(ad_in), .nf_in(nf_in),
    .swap_req_in(swap_req_in),
    .addr_out(addr_out), .rd_en_out(rd_en_out), .data_in(data_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hs_out(hs_out), .vs_out(vs_out), .ad_out(ad_out), .nf_out(nf_out),
    .bank_out(bank_out), .swap_ack_out(swap_ack_out)
  );

  always #5 clk_pixel_in = ~clk_pixel_in;

  // BRAM model: two-cycle read latency, content = address, optional override.
  logic [AW-1:0] bram_q1, bram_q2;
  logic          ovr;
  logic [15:0]   ovr_val;
  always @(posedge clk_pixel_in) begin
    bram_q1 <= addr_out;
    bram_q2 <= bram_q1;
  end
  assign data_in = ovr ? ovr_val : bram_q2[15:0];

  typedef struct { bit hs, vs, ad, nf; int r, g, b; } dly_t;
  typedef struct { int h, v; bit ad; int exp_addr; } av_t;
  typedef struct { logic [15:0] data; bit ad; int r, g, b; } cv_t;

  dly_t exp_q[$];
  int   m_bank, m_pending, m_addr;
  int   n_chk, n_fail;
  int   ack_seen, line0_addr, nf_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scale an n-bit channel to 8 bits by copying its top bits into the gap.
  function automatic int exp8(input int v, input int bits);
    return (v << (8 - bits)) | (v >> (2 * bits - 8));
  endfunction

  function automatic bit rnd_req(input bit en);
    return en && ($urandom_range(0, 999) == 0);
  endfunction

  task automatic model_reset();
    dly_t z;
    z = '{default: 0};
    m_bank = 0; m_pending = 0; m_addr = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back(z);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(addr_out), 0);
    chk({tag, "_rd_en"}, 32'(rd_en_out), 0);
    chk({tag, "_rgb"}, 32'({red_out, green_out, blue_out}), 0);
    chk({tag, "_flags"}, 32'({hs_out, vs_out, ad_out, nf_out}), 0);
    chk({tag, "_bank"}, 32'(bank_out), 0);
    chk({tag, "_ack"}, 32'(swap_ack_out), 0);
  endtask

  // One pixel clock: drive, advance the reference model, then check all outputs.
  task automatic step(input int h, input int v, input bit hs, input bit vs,
                      input bit ad, input bit nf, input bit req);
    dly_t e;
    int   d, ack;
    hcount_in = h[10:0]; vcount_in = v[9:0];
    hs_in = hs; vs_in = vs; ad_in = ad; nf_in = nf; swap_req_in = req;
    if (ad) m_addr = m_bank * FB_SIZE + (v / 4) * 320 + h / 4;
    d = ovr ? int'(ovr_val) : (m_addr % 65536);
    e.hs = hs; e.vs = vs; e.ad = ad; e.nf = nf;
    e.r = ad ? exp8((d >> 11) & 31, 5) : 0;
    e.g = ad ? exp8((d >> 5) & 63, 6) : 0;
    e.b = ad ? exp8(d & 31, 5) : 0;
    ack = 0;
    if (nf) begin
      if (m_pending != 0 || req) begin m_bank ^= 1; ack = 1; end
      m_pending = 0;
    end else if (req) begin
      m_pending = 1;
    end
    exp_q.push_back(e);
    @(posedge clk_pixel_in);
    @(negedge clk_pixel_in);
    swap_req_in = 1'b0;
    chk("addr", 32'(addr_out), m_addr);
    chk("rd_en", 32'(rd_en_out), 32'(ad));
    chk("bank", 32'(bank_out), m_bank);
    chk("swap_ack", 32'(swap_ack_out), ack);
    if (swap_ack_out) ack_seen++;
    e = exp_q.pop_front();
    chk("hs_out", 32'(hs_out), 32'(e.hs));
    chk("vs_out", 32'(vs_out), 32'(e.vs));
    chk("ad_out", 32'(ad_out), 32'(e.ad));
    chk("nf_out", 32'(nf_out), 32'(e.nf));
    chk("red", 32'(red_out), e.r);
    chk("green", 32'(green_out), e.g);
    chk("blue", 32'(blue_out), e.b);
  endtask

  task automatic do_line(input int v, input bit req, input bit rnd);
    step(0, v, $urandom_range(0, 1) == 1, 1'b0, 1'b1, 1'b0, req | rnd_req(rnd));
    if (v == 0) line0_addr = int'(addr_out);
    step($urandom_range(1, 1278), v, 1'b0, 1'b0, 1'b1, 1'b0, rnd_req(rnd));
    step($urandom_range(1, 1278), v, 1'b0, 1'b0, 1'b1, 1'b0, rnd_req(rnd));
    step(1279, v, 1'b0, 1'b0, 1'b1, 1'b0, rnd_req(rnd));
    step(1280 + $urandom_range(0, 369), v, $urandom_range(0, 1) == 1, 1'b0, 1'b0, 1'b0, rnd_req(rnd));
  endtask

  task automatic do_frame(input int ra, input int rb, input bit req_nf,
                          input bit post_req, input bit rnd);
    ack_seen = 0;
    for (int v = 0; v < 720; v++) do_line(v, (v == ra) || (v == rb), rnd);
    step(0, 720, 1'b0, 1'b1, 1'b0, 1'b1, req_nf | rnd_req(rnd));
    nf_ack = int'(swap_ack_out);
    for (int i = 1; i <= 4; i++)
      step(i * 100, 720 + i, $urandom_range(0, 1) == 1, 1'b1, 1'b0, 1'b0,
           ((i == 2) && post_req) | rnd_req(rnd));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    av_t atab[8];
    cv_t ctab[5];
    atab[0] = '{4, 0, 1'b1, 1};
    atab[1] = '{1279, 0, 1'b1, 319};
    atab[2] = '{2, 1, 1'b1, 0};
    atab[3] = '{1279, 3, 1'b1, 319};
    atab[4] = '{0, 4, 1'b1, 320};
    atab[5] = '{1300, 4, 1'b0, 320};
    atab[6] = '{1279, 4, 1'b1, 639};
    atab[7] = '{8, 7, 1'b1, 322};
    ctab[0] = '{16'hF800, 1'b1, 8'hFF, 8'h00, 8'h00};
    ctab[1] = '{16'h0841, 1'b1, 8'h08, 8'h08, 8'h08};
    ctab[2] = '{16'hFFFF, 1'b0, 8'h00, 8'h00, 8'h00};
    ctab[3] = '{16'h001F, 1'b1, 8'h00, 8'h00, 8'hFF};
    ctab[4] = '{16'h07E0, 1'b1, 8'h00, 8'hFF, 8'h00};

    n_chk = 0; n_fail = 0; ack_seen = 0; line0_addr = 0; nf_ack = 0;
    ovr = 1'b0; ovr_val = '0;
    rst_n_in = 1'b0;
    hcount_in = '0; vcount_in = '0;
    {hs_in, vs_in, ad_in, nf_in, swap_req_in} = '0;
    model_reset();
    repeat (3) @(negedge clk_pixel_in);
    chk_all_zero("reset");
    rst_n_in = 1'b1;

    // Latency: flags appear on the fourth clock after being sampled.
    step(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lat_ad_0", 32'(ad_out), 0);
    for (int j = 1; j <= 3; j++) begin
      step(1280, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lat_ad", 32'(ad_out), 32'(j == 3));
      chk("lat_hs", 32'(hs_out), 32'(j == 3));
    end
    step(0, 720, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      step(1280, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lat_nf", 32'(nf_out), 32'(j == 3));
    end

    // Colour expansion with forced BRAM data.
    ovr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ovr_val = ctab[i].data;
      step(8, 0, 1'b0, 1'b0, ctab[i].ad, 1'b0, 1'b0);
      repeat (3) step(1280, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tab_rgb", 32'({red_out, green_out, blue_out}),
          32'((ctab[i].r << 16) | (ctab[i].g << 8) | ctab[i].b));
    end
    ovr = 1'b0;
    repeat (3) step(1280, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Addressing: the 4x4 source block at the origin, then the table.
    for (int vv = 0; vv < 4; vv++)
      for (int hh = 0; hh < 4; hh++) begin
        step(hh, vv, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("block0_addr", 32'(addr_out), 0);
      end
    for (int i = 0; i < 8; i++) begin
      step(atab[i].h, atab[i].v, 1'b0, 1'b0, atab[i].ad, 1'b0, 1'b0);
      chk("tab_addr", 32'(addr_out), atab[i].exp_addr);
    end
    for (int v = 5; v < 720; v++) step(1279, v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("last_addr", 32'(addr_out), 57599);
    step(0, 720, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(100, 721, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Mid-frame request flips at the next new-frame pulse.
    do_frame(100, -1, 1'b0, 1'b0, 1'b0);
    chk("f1_first_addr", 32'(line0_addr), 0);
    chk("f1_acks", 32'(ack_seen), 1);
    chk("f1_bank", 32'(bank_out), 1);
    // Two requests collapse into one flip; frame starts in bank 1.
    do_frame(10, 500, 1'b0, 1'b0, 1'b0);
    chk("f2_first_addr", 32'(line0_addr), 57600);
    chk("f2_acks", 32'(ack_seen), 1);
    chk("f2_bank", 32'(bank_out), 0);
    // Request coincident with nf, then a request after nf.
    do_frame(-1, -1, 1'b1, 1'b1, 1'b0);
    chk("f3_nf_ack", 32'(nf_ack), 1);
    chk("f3_acks", 32'(ack_seen), 1);
    chk("f3_bank", 32'(bank_out), 1);
    do_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    chk("f4_first_addr", 32'(line0_addr), 57600);
    chk("f4_acks", 32'(ack_seen), 1);
    chk("f4_bank", 32'(bank_out), 0);
    // Random requests throughout.
    do_frame(-1, -1, 1'b0, 1'b0, 1'b1);

    // Reset mid-line with a request pending and one held during reset.
    for (int v = 0; v < 300; v++) do_line(v, v == 50, 1'b0);
    step(600, 300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n_in = 1'b0;
    swap_req_in = 1'b1;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk_pixel_in);
    swap_req_in = 1'b0;
    ad_in = 1'b0;
    rst_n_in = 1'b1;
    model_reset();
    do_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_first_addr", 32'(line0_addr), 0);
    chk("post_rst_acks", 32'(ack_seen), 0);
    chk("post_rst_bank", 32'(bank_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
